lbus_master: RTL and testbench
==============================

Name: lbus_master

Overview:
- Controller-side initiator for the 16-bit local bus that the cryptographic FPGA's bus slave responds to.
- Receives a byte-stream command protocol from the host link (USB FIFO / UART bridge) and translates each command into timed lbus write or read cycles.
- Read data goes back to the host over a byte-stream return channel.
- Sits in the control FPGA between the host link and the inter-FPGA lbus pins.

Parameters:
WR_PULSE, 4, cycles lbus_wr is held high per write (min 2; slave edge-detects through 2-stage synchroniser)
WR_HOLD, 2, cycles lbus_a/lbus_di stay stable after lbus_wr falls
RD_SETUP, 3, cycles address is driven with lbus_rd low before lbus_rd rises (slave output tracks address)
RD_HOLD, 2, cycles lbus_rd is high before lbus_do is sampled
POLL_MAX, 16'hFFFF, maximum read iterations of a poll command (optional feature)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
rx_data  in  8  command byte from host link
rx_valid  in  1  rx_data valid
rx_ready  out  1  block accepts rx_data this cycle
tx_data  out  8  response byte to host link
tx_valid  out  1  tx_data valid
tx_ready  in  1  host link accepts tx_data
lbus_a  out  16  bus address
lbus_di  out  16  write data, controller -> crypto module
lbus_do  in  16  read data, crypto module -> controller
lbus_wr  out  1  write strobe, active-high
lbus_rd  out  1  read freeze strobe, active-high (slave output frozen while high)
busy  out  1  high in every state except IDLE
cmd_err  out  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset: all outputs 0; FSM in IDLE.
- Byte transfer: a byte moves only when valid&ready are both high in the same cycle.
- rx_ready is high only in the byte-collecting states (IDLE, GET_AH, GET_AL, GET_DH, GET_DL).
- Command format, all fields big-endian:
  - write: 0x01, AH, AL, DH, DL
  - read: 0x00, AH, AL
  - poll: 0x02, AH, AL, MH, ML (optional feature)
- FSM states: IDLE -> GET_AH -> GET_AL -> {GET_DH -> GET_DL}; then WR_ASSERT -> WR_HOLD -> IDLE, or RD_SETUP -> RD_SAMPLE -> TX_H -> TX_L -> IDLE.
- Bus drive timing: lbus_a is loaded when AL is accepted; lbus_di is loaded when DL is accepted. Both remain stable until the next command loads new values.
- Write cycle:
  - lbus_wr rises the cycle after DL is accepted and stays high exactly WR_PULSE cycles.
  - WR_HOLD idle cycles follow, then IDLE.
  - No response bytes.
- Read cycle:
  - lbus_rd stays 0 for RD_SETUP cycles after AL is accepted.
  - lbus_rd is then 1 for RD_HOLD cycles; lbus_do is registered on the last of those cycles.
  - lbus_rd returns to 0 after sampling.
- Read response: tx_valid with tx_data = data[15:8] (TX_H), then data[7:0] (TX_L). Each byte is held until tx_ready; no byte is dropped or duplicated under backpressure.
- Unknown opcode in IDLE: the byte is consumed, cmd_err pulses one cycle, FSM stays in IDLE. Following bytes are parsed as new opcodes.
- lbus_wr and lbus_rd are never high simultaneously. Both are 0 in IDLE.
- Reset mid-operation: outputs go to 0 asynchronously. Partially received commands and pending response bytes are discarded. A strobe in flight is cut short and is not resumed.
- No inter-byte timeout; a stalled host leaves the FSM waiting in its GET state indefinitely.

Optional Feature:
- Macro LBUS_POLL_EN.
- Defined:
  - Opcode 0x02 repeats full read cycles at address A until (data & M)==0 or POLL_MAX reads have completed.
  - A 16-bit iteration counter, reset per command, counts the reads.
  - Response is 3 bytes: status (0x00 = condition met, 0xFF = POLL_MAX exhausted), then data hi, data lo of the last read.
  - Intended use: wait for the slave busy bit (ctrl register 0x0002, bit 0) to clear.
- Undefined: 0x02 is an unknown opcode (cmd_err pulse); no counter logic is synthesised.

Test Plan:
- Write: rx 01 01 00 12 34 -> lbus_a=0x0100, lbus_di=0x1234, lbus_wr high exactly 4 cycles, a/di unchanged for at least 2 further cycles, no tx bytes, busy low afterwards.
- Read: rx 00 FF FC, slave model returns 0x4702 at 0xFFFC -> lbus_rd low 3 cycles then high 2 cycles; tx bytes 0x47, 0x02 in order.
- Backpressure: read of 0x0180 returning 0xA5C3 with tx_ready low 10 cycles -> tx_valid held with tx_data=0xA5 stable; then 0xC3 once; rx_ready stays low until TX_L completes.
- Unknown opcode: rx 7E then 00 00 02 (ctrl=0x0001) -> one cmd_err pulse; response bytes 00 01.
- Reset mid-write: assert rst during 2nd lbus_wr cycle -> lbus_wr=0 immediately, all outputs 0; subsequent write 01 00 0C 00 01 completes normally.
- Poll (LBUS_POLL_EN): rx 02 00 02 00 01, slave ctrl bit0 clears after 5 reads -> tx 00 00 00; with bit0 never clearing and POLL_MAX=8 -> exactly 8 read cycles, tx FF 00 01.

Source files
------------

// File: rtl/lbus_master_if.sv
// Host byte-stream channels and lbus pins for lbus_master.
// master: the lbus_master view; slave: the host link plus crypto-side bus slave.
interface lbus_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] lbus_a;
  logic [15:0] lbus_di;
  logic [15:0] lbus_do;
  logic        lbus_wr;
  logic        lbus_rd;

  modport master (
    input  rx_data, rx_valid, tx_ready, lbus_do,
    output rx_ready, tx_data, tx_valid, lbus_a, lbus_di, lbus_wr, lbus_rd
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, lbus_do,
    input  rx_ready, tx_data, tx_valid, lbus_a, lbus_di, lbus_wr, lbus_rd
  );
endinterface

// File: rtl/lbus_master.sv
// lbus_master: turns host byte-stream commands into timed 16-bit lbus write/read cycles.
// Define LBUS_POLL_EN to add the 0x02 poll command, bounded by POLL_MAX reads.
module lbus_master #(
  parameter int WR_PULSE = 4,
  parameter int WR_HOLD  = 2,
  parameter int RD_SETUP = 3,
  parameter int RD_HOLD  = 2
`ifdef LBUS_POLL_EN
  ,
  parameter logic [15:0] POLL_MAX = 16'hFFFF
`endif
) (
  input  logic          clk,
  input  logic          rst,
  lbus_master_if.master bus,
  output logic          busy,
  output logic          cmd_err
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_GET_AH, ST_GET_AL, ST_GET_DH, ST_GET_DL,
    ST_WR_ASSERT, ST_WR_HOLD, ST_RD_SETUP, ST_RD_SAMPLE,
    ST_TX_S, ST_TX_H, ST_TX_L
  } state_t;

  typedef enum logic [1:0] {OP_RD = 2'd0, OP_WR = 2'd1, OP_POLL = 2'd2} op_t;

  localparam logic [7:0] WR_PULSE_LAST = 8'(WR_PULSE - 1);
  localparam logic [7:0] WR_HOLD_LAST  = 8'(WR_HOLD - 1);
  localparam logic [7:0] RD_SETUP_LAST = 8'(RD_SETUP - 1);
  localparam logic [7:0] RD_HOLD_LAST  = 8'(RD_HOLD - 1);

  state_t      state_r, state_n;
  op_t         op_r, op_n;
  logic [7:0]  cnt_r, cnt_n, hi_r, hi_n;
  logic [15:0] a_r, a_n, di_r, di_n, data_r, data_n;
  logic        rx_acc_s, tx_acc_s, err_s;
  logic [7:0]  tx_data_s;
  logic        rx_ready_r, tx_valid_r, wr_r, rd_r, busy_r, cmd_err_r;
  logic [7:0]  tx_data_r;
`ifdef LBUS_POLL_EN
  logic [15:0] mask_r, mask_n, iter_r, iter_n;
  logic [7:0]  stat_r, stat_n;
`endif

  assign rx_acc_s = bus.rx_valid & bus.rx_ready;
  assign tx_acc_s = bus.tx_valid & bus.tx_ready;

  // Next-state, datapath updates and the value the tx byte register loads.
  always_comb begin
    state_n = state_r;
    op_n    = op_r;
    cnt_n   = cnt_r;
    hi_n    = hi_r;
    a_n     = a_r;
    di_n    = di_r;
    data_n  = data_r;
    err_s   = 1'b0;
`ifdef LBUS_POLL_EN
    mask_n  = mask_r;
    iter_n  = iter_r;
    stat_n  = stat_r;
`endif
    case (state_r)
      ST_IDLE: begin
        if (rx_acc_s) begin
          case (bus.rx_data)
            8'h00:   begin op_n = OP_RD; state_n = ST_GET_AH; end
            8'h01:   begin op_n = OP_WR; state_n = ST_GET_AH; end
`ifdef LBUS_POLL_EN
            8'h02:   begin op_n = OP_POLL; state_n = ST_GET_AH; end
`endif
            default: err_s = 1'b1;
          endcase
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_GET_AH: begin
        if (rx_acc_s) begin
          hi_n    = bus.rx_data;
          state_n = ST_GET_AL;
        end else begin
          state_n = ST_GET_AH;
        end
      end
      ST_GET_AL: begin
        if (rx_acc_s) begin
          a_n     = {hi_r, bus.rx_data};
          cnt_n   = 8'd0;
          state_n = (op_r == OP_RD) ? ST_RD_SETUP : ST_GET_DH;
        end else begin
          state_n = ST_GET_AL;
        end
      end
      ST_GET_DH: begin
        if (rx_acc_s) begin
          hi_n    = bus.rx_data;
          state_n = ST_GET_DL;
        end else begin
          state_n = ST_GET_DH;
        end
      end
      ST_GET_DL: begin
        if (rx_acc_s) begin
          cnt_n = 8'd0;
`ifdef LBUS_POLL_EN
          if (op_r == OP_WR) begin
            di_n    = {hi_r, bus.rx_data};
            state_n = ST_WR_ASSERT;
          end else begin
            mask_n  = {hi_r, bus.rx_data};
            iter_n  = 16'd0;
            state_n = ST_RD_SETUP;
          end
`else
          di_n    = {hi_r, bus.rx_data};
          state_n = ST_WR_ASSERT;
`endif
        end else begin
          state_n = ST_GET_DL;
        end
      end
      ST_WR_ASSERT: begin
        if (cnt_r == WR_PULSE_LAST) begin
          cnt_n   = 8'd0;
          state_n = ST_WR_HOLD;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_WR_HOLD: begin
        if (cnt_r == WR_HOLD_LAST) begin
          cnt_n   = 8'd0;
          state_n = ST_IDLE;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_RD_SETUP: begin
        if (cnt_r == RD_SETUP_LAST) begin
          cnt_n   = 8'd0;
          state_n = ST_RD_SAMPLE;
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_RD_SAMPLE: begin
        if (cnt_r == RD_HOLD_LAST) begin
          data_n = bus.lbus_do;
          cnt_n  = 8'd0;
`ifdef LBUS_POLL_EN
          if (op_r == OP_POLL) begin
            iter_n = iter_r + 16'd1;
            if ((bus.lbus_do & mask_r) == 16'h0000) begin
              stat_n  = 8'h00;
              state_n = ST_TX_S;
            end else if (iter_n == POLL_MAX) begin
              stat_n  = 8'hFF;
              state_n = ST_TX_S;
            end else begin
              state_n = ST_RD_SETUP;
            end
          end else begin
            state_n = ST_TX_H;
          end
`else
          state_n = ST_TX_H;
`endif
        end else begin
          cnt_n = cnt_r + 8'd1;
        end
      end
      ST_TX_S: state_n = tx_acc_s ? ST_TX_H : ST_TX_S;
      ST_TX_H: state_n = tx_acc_s ? ST_TX_L : ST_TX_H;
      ST_TX_L: state_n = tx_acc_s ? ST_IDLE : ST_TX_L;
      default: state_n = ST_IDLE;
    endcase

    case (state_n)
      ST_TX_H: tx_data_s = data_n[15:8];
      ST_TX_L: tx_data_s = data_n[7:0];
`ifdef LBUS_POLL_EN
      ST_TX_S: tx_data_s = stat_n;
`endif
      default: tx_data_s = 8'h00;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_n;
  end

  // Datapath registers; outputs are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= OP_RD;
      cnt_r      <= 8'd0;
      hi_r       <= 8'd0;
      a_r        <= 16'd0;
      di_r       <= 16'd0;
      data_r     <= 16'd0;
      rx_ready_r <= 1'b0;
      tx_valid_r <= 1'b0;
      tx_data_r  <= 8'd0;
      wr_r       <= 1'b0;
      rd_r       <= 1'b0;
      busy_r     <= 1'b0;
      cmd_err_r  <= 1'b0;
`ifdef LBUS_POLL_EN
      mask_r     <= 16'd0;
      iter_r     <= 16'd0;
      stat_r     <= 8'd0;
`endif
    end else begin
      op_r       <= op_n;
      cnt_r      <= cnt_n;
      hi_r       <= hi_n;
      a_r        <= a_n;
      di_r       <= di_n;
      data_r     <= data_n;
      rx_ready_r <= (state_n inside {ST_IDLE, ST_GET_AH, ST_GET_AL, ST_GET_DH, ST_GET_DL});
      tx_valid_r <= (state_n inside {ST_TX_S, ST_TX_H, ST_TX_L});
      tx_data_r  <= tx_data_s;
      wr_r       <= (state_n == ST_WR_ASSERT);
      rd_r       <= (state_n == ST_RD_SAMPLE);
      busy_r     <= (state_n != ST_IDLE);
      cmd_err_r  <= err_s;
`ifdef LBUS_POLL_EN
      mask_r     <= mask_n;
      iter_r     <= iter_n;
      stat_r     <= stat_n;
`endif
    end
  end

  assign bus.rx_ready = rx_ready_r;
  assign bus.tx_valid = tx_valid_r;
  assign bus.tx_data  = tx_data_r;
  assign bus.lbus_a   = a_r;
  assign bus.lbus_di  = di_r;
  assign bus.lbus_wr  = wr_r;
  assign bus.lbus_rd  = rd_r;
  assign busy         = busy_r;
  assign cmd_err      = cmd_err_r;

endmodule

// File: tb/tb_lbus_master.sv
// Directed self-checking bench for lbus_master: write, read, backpressure,
// unknown opcode, reset mid-write and (with LBUS_POLL_EN) poll commands.
module tb_lbus_master;
  logic clk;
  logic rst;
  logic busy;
  logic cmd_err;

  lbus_master_if bif ();

  lbus_master #(
    .WR_PULSE(4)
`ifdef LBUS_POLL_EN
    , .POLL_MAX(16'd8)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bif.master),
    .busy    (busy),
    .cmd_err (cmd_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] txq[$];
  int   err_cycles = 0;
  int   rd_rises   = 0;
  int   overlap_n  = 0;
  int   rx_in_tx_n = 0;
  logic rd_prev;
  bit   poll_clear = 1'b0;
  int   poll_base  = 0;

  // Slave model: 0x0002 is a ctrl register whose bit 0 clears after 5 reads when poll_clear is set.
  function automatic logic [15:0] slave_do(input logic [15:0] a, input int rises, input bit clr);
    case (a)
      16'hFFFC: return 16'h4702;
      16'h0180: return 16'hA5C3;
      16'h0002: return (clr && (rises - poll_base) > 5) ? 16'h0000 : 16'h0001;
      default:  return 16'h0000;
    endcase
  endfunction

  assign bif.lbus_do = slave_do(bif.lbus_a, rd_rises, poll_clear);

  always @(posedge clk) begin
    if (bif.tx_valid && bif.tx_ready) txq.push_back(bif.tx_data);
    if (cmd_err) err_cycles <= err_cycles + 1;
    if (bif.lbus_rd && !rd_prev) rd_rises <= rd_rises + 1;
    rd_prev <= bif.lbus_rd;
    if (bif.lbus_wr && bif.lbus_rd) overlap_n <= overlap_n + 1;
    if (bif.tx_valid && bif.rx_ready) rx_in_tx_n <= rx_in_tx_n + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [7:0] txb(input int i);
    if (i < txq.size()) return txq[i];
    else return 8'hxx;
  endfunction

  // Called at a negedge; returns at the negedge right after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      if (bif.rx_ready) ok = 1'b1;
      @(negedge clk);
    end
    bif.rx_valid = 1'b0;
    check("rx_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int t = 0; t < 500 && busy; t++) @(negedge clk);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic write_and_check(input logic [15:0] a, input logic [15:0] d, input string tag);
    logic [6:0] wr_pat, busy_pat;
    int bad, base;
    bad  = 0;
    base = txq.size();
    send_byte(8'h01); send_byte(a[15:8]); send_byte(a[7:0]);
    send_byte(d[15:8]); send_byte(d[7:0]);
    for (int i = 0; i < 7; i++) begin
      wr_pat[i]   = bif.lbus_wr;
      busy_pat[i] = busy;
      if (bif.lbus_a !== a || bif.lbus_di !== d) bad++;
      @(negedge clk);
    end
    check({tag, "_wr_pulse"}, 32'(wr_pat), 32'h0F);
    check({tag, "_busy"}, 32'(busy_pat), 32'h3F);
    check({tag, "_a_di_stable"}, 32'(bad), 32'd0);
    check({tag, "_addr"}, 32'(bif.lbus_a), 32'(a));
    check({tag, "_data"}, 32'(bif.lbus_di), 32'(d));
    check({tag, "_no_tx"}, 32'(txq.size() - base), 32'd0);
  endtask

  initial begin
    logic [5:0] rd_pat;
    int base, bad, rxb, eb, rb;
    clk = 1'b0;
    rst = 1'b1;
    bif.rx_data  = 8'h00;
    bif.rx_valid = 1'b0;
    bif.tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_di", {bif.lbus_a, bif.lbus_di}, 32'd0);
    check("rst_ctl", 32'({bif.rx_ready, bif.tx_valid, bif.tx_data, bif.lbus_wr,
                          bif.lbus_rd, busy, cmd_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_rx_ready", 32'(bif.rx_ready), 32'd1);
    bif.tx_ready = 1'b1;

    write_and_check(16'h0100, 16'h1234, "wr");

    // Read: rd low 3 cycles, high 2, then two response bytes.
    base = txq.size();
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFC);
    for (int i = 0; i < 6; i++) begin
      rd_pat[i] = bif.lbus_rd;
      @(negedge clk);
    end
    check("rd_strobe", 32'(rd_pat), 32'h18);
    check("rd_addr", 32'(bif.lbus_a), 32'h0000FFFC);
    wait_idle("rd_idle");
    check("rd_tx_n", 32'(txq.size() - base), 32'd2);
    check("rd_tx_hi", 32'(txb(base)), 32'h47);
    check("rd_tx_lo", 32'(txb(base + 1)), 32'h02);

    // Backpressure: first byte held 10 cycles.
    bif.tx_ready = 1'b0;
    base = txq.size();
    rxb  = rx_in_tx_n;
    bad  = 0;
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h80);
    for (int t = 0; t < 50 && !bif.tx_valid; t++) @(negedge clk);
    check("bp_tx_valid", 32'(bif.tx_valid), 32'd1);
    repeat (10) begin
      if (!(bif.tx_valid && bif.tx_data == 8'hA5 && !bif.rx_ready)) bad++;
      @(negedge clk);
    end
    check("bp_hold", 32'(bad), 32'd0);
    bif.tx_ready = 1'b1;
    wait_idle("bp_idle");
    check("bp_tx_n", 32'(txq.size() - base), 32'd2);
    check("bp_tx_hi", 32'(txb(base)), 32'hA5);
    check("bp_tx_lo", 32'(txb(base + 1)), 32'hC3);
    check("bp_rx_ready_low", 32'(rx_in_tx_n - rxb), 32'd0);

    // Unknown opcode, then a read of ctrl.
    eb   = err_cycles;
    base = txq.size();
    send_byte(8'h7E);
    check("unk_idle", 32'(busy), 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h02);
    wait_idle("unk_rd_idle");
    check("unk_err_pulse", 32'(err_cycles - eb), 32'd1);
    check("unk_tx_n", 32'(txq.size() - base), 32'd2);
    check("unk_tx_hi", 32'(txb(base)), 32'h00);
    check("unk_tx_lo", 32'(txb(base + 1)), 32'h01);

    // Reset during the 2nd write-strobe cycle.
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h20); send_byte(8'hBE); send_byte(8'hEF);
    check("rw_wr_started", 32'(bif.lbus_wr), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rw_wr_cut", 32'(bif.lbus_wr), 32'd0);
    check("rw_a_di", {bif.lbus_a, bif.lbus_di}, 32'd0);
    check("rw_ctl", 32'({bif.rx_ready, bif.tx_valid, bif.tx_data, bif.lbus_rd, busy, cmd_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rw_no_resume", 32'({bif.lbus_wr, busy}), 32'd0);
    write_and_check(16'h000C, 16'h0001, "wr2");

`ifdef LBUS_POLL_EN
    // Poll until ctrl bit 0 clears: reads 1..5 see 1, read 6 sees 0.
    poll_clear = 1'b1;
    poll_base  = rd_rises;
    rb   = rd_rises;
    base = txq.size();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    wait_idle("poll_idle");
    check("poll_reads", 32'(rd_rises - rb), 32'd6);
    check("poll_tx_n", 32'(txq.size() - base), 32'd3);
    check("poll_stat", 32'(txb(base)), 32'h00);
    check("poll_hi", 32'(txb(base + 1)), 32'h00);
    check("poll_lo", 32'(txb(base + 2)), 32'h00);

    // Bit never clears: exactly POLL_MAX (8) reads.
    poll_clear = 1'b0;
    rb   = rd_rises;
    base = txq.size();
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    wait_idle("pmax_idle");
    check("pmax_reads", 32'(rd_rises - rb), 32'd8);
    check("pmax_tx_n", 32'(txq.size() - base), 32'd3);
    check("pmax_stat", 32'(txb(base)), 32'hFF);
    check("pmax_hi", 32'(txb(base + 1)), 32'h00);
    check("pmax_lo", 32'(txb(base + 2)), 32'h01);
`endif

    check("wr_rd_overlap", 32'(overlap_n), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
